// File: rtl/sprite_blitter_pkg.sv
// Shared definitions for the sprite blitter slice.
// Contents:
//   - sprite geometry and derived counter/address widths
//   - visible screen limits of the 160x120 VGA adapter
//   - 3-bit RGB colour constants, including the transparent key colour
//   - sprite ID constants
//   - blitter FSM state encoding
//   - sprite_pixel(): the built-in 4 x 8x8 bitmap table the sprite ROM serves
package sprite_blitter_pkg;

   localparam int SPRITE_W = 8;
   localparam int SPRITE_H = 8;
   localparam int COL_W    = $clog2(SPRITE_W);
   localparam int ROW_W    = $clog2(SPRITE_H);
   localparam int PIX_W    = ROW_W + COL_W;
   localparam int ID_W     = 2;
   localparam int ROM_AW   = ID_W + PIX_W;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   // Colours are {R,G,B}.
   typedef logic [2:0] colour_t;
   localparam colour_t BLACK      = 3'b000;
   localparam colour_t BLUE       = 3'b001;
   localparam colour_t GREEN      = 3'b010;
   localparam colour_t BLUE_SKY   = 3'b011;
   localparam colour_t RED        = 3'b100;
   localparam colour_t KEY_COLOUR = 3'b101;
   localparam colour_t YELLOW     = 3'b110;
   localparam colour_t WHITE      = 3'b111;

   localparam logic [ID_W-1:0] SPR_DUCK_UP   = 2'd0;
   localparam logic [ID_W-1:0] SPR_DUCK_DOWN = 2'd1;
   localparam logic [ID_W-1:0] SPR_DUCK_FALL = 2'd2;
   localparam logic [ID_W-1:0] SPR_CROSSHAIR = 2'd3;

   typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

   // Bitmap table indexed by {id,row,col}; KEY_COLOUR marks see-through pixels.
   function automatic colour_t sprite_pixel(input logic [ROM_AW-1:0] addr);
      logic [ID_W-1:0]  id;
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
      {id, row, col} = addr;
      case (id)
         SPR_DUCK_UP:   return RED;
         SPR_DUCK_DOWN: return (row[0] == col[0]) ? GREEN : KEY_COLOUR;
         SPR_DUCK_FALL: return (col >= row) ? YELLOW : KEY_COLOUR;
         default:       return (row == ROW_W'(3) || col == COL_W'(3)) ? WHITE : KEY_COLOUR;
      endcase
   endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Request/pixel bus of the sprite blitter.
//   master: movement/HUD logic side (drives the request, watches busy/done and pixels)
//   slave : the blitter (accepts the request, drives busy/done and the VGA pixel write)
// Signals: start, sprite_id[1:0], x0[7:0], y0[6:0], erase   (request)
//          busy, done                                       (status)
//          x_out[7:0], y_out[6:0], colour_out[2:0], plot   (VGA pixel write)
interface sprite_blitter_if;
   import sprite_blitter_pkg::*;

   logic            start;
   logic [ID_W-1:0] sprite_id;
   logic [7:0]      x0;
   logic [6:0]      y0;
   logic            erase;
   logic            busy;
   logic            done;
   logic [7:0]      x_out;
   logic [6:0]      y_out;
   colour_t         colour_out;
   logic            plot;

   modport master (
      output start, sprite_id, x0, y0, erase,
      input  busy, done, x_out, y_out, colour_out, plot
   );

   modport slave (
      input  start, sprite_id, x0, y0, erase,
      output busy, done, x_out, y_out, colour_out, plot
   );

endinterface

// File: rtl/sprite_rom.sv
// Synchronous sprite bitmap ROM: 4 sprites x 8x8 words x 3 bits, contents from
// the package bitmap table. Registered read data, one cycle of latency.
// Ports:
//   clk  in   clock
//   addr in   {sprite_id, row, col}
//   q    out  pixel colour for the address presented on the previous edge
module sprite_rom
   import sprite_blitter_pkg::*;
(
   input  logic              clk,
   input  logic [ROM_AW-1:0] addr,
   output colour_t           q
);

   // NOTE: ROM read data has no reset; whoever consumes q qualifies it with a
   // separately reset valid bit, which keeps this mappable onto block RAM.
   always_ff @(posedge clk) begin
      q <= sprite_pixel(addr);
   end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: takes one draw/erase request for an 8x8 sprite and walks the
// bitmap row-major, emitting one registered pixel write per cycle to the VGA port.
// Transparent (key-colour) and off-screen pixels are suppressed without
// changing the 66-cycle request timing.
// Ports:
//   clk     in  clock
//   resetn  in  asynchronous active-low reset
//   bus     slave side of sprite_blitter_if (request, busy/done, pixel write)
module sprite_blitter
   import sprite_blitter_pkg::*;
#(
   parameter int      NUM_SPRITES = 4,
   parameter colour_t BG_COLOUR   = BLACK
) (
   input  logic           clk,
   input  logic           resetn,
   sprite_blitter_if.slave bus
);

   localparam logic [8:0] X_LIM = 9'(SCREEN_W);
   localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

   state_t           state_q, state_d;
   logic             load, advance;

   logic [ID_W-1:0]  id_q;
   logic [7:0]       x0_q;
   logic [6:0]       y0_q;
   logic             erase_q;
   logic             id_ok_q;
   logic [PIX_W-1:0] pix_q;      // {row, col}; col is the fast-moving part

   colour_t          rom_q;
   logic [8:0]       px_q;       // coordinates aligned with rom_q
   logic [7:0]       py_q;
   logic             pv_q;

   logic             busy_q, done_q, plot_q;
   logic [7:0]       x_out_q;
   logic [6:0]       y_out_q;
   colour_t          colour_q;

   // NOTE: every sequential block uses non-blocking assignments so all
   // registers update together from the values present before the edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = READ;
            end
         end
         READ: begin
            advance = 1'b1;
            if (&pix_q) state_d = FLUSH;
         end
         FLUSH:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request is captured once and held for the whole walk.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         id_q    <= '0;
         x0_q    <= '0;
         y0_q    <= '0;
         erase_q <= 1'b0;
         id_ok_q <= 1'b0;
         pix_q   <= '0;
      end else if (load) begin
         id_q    <= bus.sprite_id;
         x0_q    <= bus.x0;
         y0_q    <= bus.y0;
         erase_q <= bus.erase;
         id_ok_q <= int'(bus.sprite_id) < NUM_SPRITES;
         pix_q   <= '0;
      end else if (advance) begin
         pix_q   <= pix_q + PIX_W'(1);
      end
   end

   sprite_rom u_rom (
      .clk  (clk),
      .addr ({id_q, pix_q}),
      .q    (rom_q)
   );

   // Coordinates ride alongside the ROM read so both arrive together.
   // Widened by one bit so off-screen positions never wrap back on screen.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         px_q <= '0;
         py_q <= '0;
         pv_q <= 1'b0;
      end else begin
         px_q <= 9'(x0_q) + 9'(pix_q[COL_W-1:0]);
         py_q <= 8'(y0_q) + 8'(pix_q[PIX_W-1:COL_W]);
         pv_q <= (state_q == READ) && id_ok_q;
      end
   end

   // Output stage. busy/done follow the FSM by one cycle so they line up with
   // the pixel pipeline; pixel fields hold their last value when plot is low.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         plot_q   <= 1'b0;
         x_out_q  <= '0;
         y_out_q  <= '0;
         colour_q <= BLACK;
      end else begin
         busy_q <= (state_q != IDLE);
         done_q <= (state_q == DONE);
         plot_q <= 1'b0;
         if (pv_q && (rom_q != KEY_COLOUR) && (px_q < X_LIM) && (py_q < Y_LIM)) begin
            plot_q   <= 1'b1;
            x_out_q  <= px_q[7:0];
            y_out_q  <= py_q[6:0];
            colour_q <= erase_q ? BG_COLOUR : rom_q;
         end
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.plot       = plot_q;
   assign bus.x_out      = x_out_q;
   assign bus.y_out      = y_out_q;
   assign bus.colour_out = colour_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter. A reference model turns each accepted
// request into a per-edge table of expected busy/done/plot/x/y/colour values,
// computed straight from the request rules; a monitor compares the DUT against
// that table every cycle on the falling edge.
module tb_sprite_blitter;

   localparam int MAXE = 8192;

   typedef struct {
      bit busy;
      bit done;
      bit plot;
      int x;
      int y;
      int c;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   sprite_blitter_if bus();

   sprite_blitter u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   edge_n  = 0;
   int   next_free = 0;
   int   last_t  = -1000;
   int   plot_cnt = 0;
   int   mx = 0, my = 0, mc = 0;
   exp_t exp_q [MAXE];

   task automatic check(input string tag, input int got, input int expv);
      n_tests++;
      if (got != expv) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_n, got, expv);
      end
   endtask

   // Sprite bitmaps as described for the game.
   function automatic int ref_pixel(input int id, input int r, input int c);
      case (id)
         0:       return 4;                              // solid red
         1:       return ((r + c) % 2 == 0) ? 2 : 5;     // green checkerboard
         2:       return (c >= r) ? 6 : 5;               // yellow upper triangle
         default: return (r == 3 || c == 3) ? 7 : 5;     // white cross
      endcase
   endfunction

   // Request sampled at edge t: busy for t+1..t+66, pixel k at t+2+k, done at t+66.
   task automatic accept(input int t);
      int id, x0, y0, er;
      id = int'(bus.sprite_id);
      x0 = int'(bus.x0);
      y0 = int'(bus.y0);
      er = int'(bus.erase);
      if (t + 70 >= MAXE) begin
         $display("FAIL model_range: edge %0d beyond table size %0d", t, MAXE);
         $fatal(1, "model table exhausted");
      end
      last_t    = t;
      next_free = t + 67;
      for (int e = t + 1; e <= t + 66; e++) begin
         exp_q[e] = '{default: 0};
         exp_q[e].busy = 1'b1;
         exp_q[e].done = (e == t + 66);
      end
      for (int k = 0; k < 64; k++) begin
         int r, c, x, y, p;
         r = k / 8;
         c = k % 8;
         x = x0 + c;
         y = y0 + r;
         p = ref_pixel(id, r, c);
         if (id < 4 && p != 5 && x < 160 && y < 120) begin
            exp_q[t + 2 + k].plot = 1'b1;
            exp_q[t + 2 + k].x    = x;
            exp_q[t + 2 + k].y    = y;
            exp_q[t + 2 + k].c    = er ? 0 : p;
         end
      end
   endtask

   task automatic model_reset();
      for (int e = edge_n + 1; e < MAXE; e++) exp_q[e] = '{default: 0};
      next_free = 0;
      mx = 0;
      my = 0;
      mc = 0;
   endtask

   always @(posedge clk) begin
      edge_n++;
      if (resetn && bus.start && edge_n >= next_free) accept(edge_n);
   end

   always @(negedge clk) begin
      exp_t ex;
      ex = exp_q[edge_n];
      if (ex.plot) begin
         mx = ex.x;
         my = ex.y;
         mc = ex.c;
      end
      check("busy",   int'(bus.busy), int'(ex.busy));
      check("done",   int'(bus.done), int'(ex.done));
      check("plot",   int'(bus.plot), int'(ex.plot));
      check("x_out",  int'(bus.x_out), mx);
      check("y_out",  int'(bus.y_out), my);
      check("colour", int'(bus.colour_out), mc);
      if (bus.plot) begin
         plot_cnt++;
         check("x_visible", int'(bus.x_out < 8'd160), 1);
      end
   end

   // Called at a falling edge: the request is sampled on the next rising edge.
   task automatic pulse(input int id, input int x0, input int y0, input bit er);
      bus.sprite_id = 2'(id);
      bus.x0        = 8'(x0);
      bus.y0        = 7'(y0);
      bus.erase     = er;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   // Returns at the falling edge that follows rising edge e.
   task automatic wait_edge(input int e);
      for (int i = 0; i < 300 && edge_n < e; i++) @(negedge clk);
      if (edge_n != e) check("wait_edge", edge_n, e);
   endtask

   task automatic run_counted(input int id, input int x0, input int y0, input bit er,
                              input string tag, input int want_plots);
      int c0, t;
      c0 = plot_cnt;
      pulse(id, x0, y0, er);
      t = last_t;
      wait_edge(t + 67);
      check(tag, plot_cnt - c0, want_plots);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      bus.start     = 1'b0;
      bus.sprite_id = '0;
      bus.x0        = '0;
      bus.y0        = '0;
      bus.erase     = 1'b0;

      // Reset and idle
      repeat (3) @(negedge clk);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_plot", int'(bus.plot), 0);
      resetn = 1'b1;
      check("rst_done",   int'(bus.done), 0);
      check("rst_x",      int'(bus.x_out), 0);
      check("rst_y",      int'(bus.y_out), 0);
      check("rst_colour", int'(bus.colour_out), 0);
      repeat (100) @(negedge clk);
      check("idle_plots", plot_cnt, 0);

      // Full opaque draw
      pulse(0, 10, 20, 1'b0);
      t = last_t;
      wait_edge(t + 1);
      check("draw_busy_rise", int'(bus.busy), 1);
      wait_edge(t + 2);
      check("draw_first_plot", int'(bus.plot), 1);
      check("draw_first_x", int'(bus.x_out), 10);
      check("draw_first_y", int'(bus.y_out), 20);
      check("draw_colour", int'(bus.colour_out), 4);
      wait_edge(t + 65);
      check("draw_last_x", int'(bus.x_out), 17);
      check("draw_last_y", int'(bus.y_out), 27);
      wait_edge(t + 66);
      check("draw_done", int'(bus.done), 1);
      wait_edge(t + 67);
      check("draw_idle", int'(bus.busy), 0);
      check("draw_plots", plot_cnt, 64);

      // Transparency, then erase of the same footprint
      run_counted(1, 0, 0, 1'b0, "checker_plots", 32);
      run_counted(1, 0, 0, 1'b1, "erase_plots", 32);

      // Clipping at the bottom-right corner
      run_counted(0, 156, 116, 1'b0, "clip_plots", 16);

      // Start while busy is ignored; start at T+67 is taken
      pulse(0, 30, 40, 1'b0);
      t = last_t;
      wait_edge(t + 9);
      pulse(0, 90, 40, 1'b0);
      wait_edge(t + 12);
      check("ignored_start_x", int'(bus.x_out), 32);
      wait_edge(t + 66);
      check("b2b_done", int'(bus.done), 1);
      pulse(0, 50, 60, 1'b0);
      wait_edge(t + 69);
      check("b2b_first_plot", int'(bus.plot), 1);
      check("b2b_first_x", int'(bus.x_out), 50);
      check("b2b_first_y", int'(bus.y_out), 60);
      wait_edge(last_t + 67);

      // Reset in the middle of a walk
      pulse(2, 40, 30, 1'b0);
      t = last_t;
      wait_edge(t + 30);
      #2;
      resetn = 1'b0;
      model_reset();
      #1;
      check("midrst_busy",   int'(bus.busy), 0);
      check("midrst_plot",   int'(bus.plot), 0);
      check("midrst_done",   int'(bus.done), 0);
      check("midrst_x",      int'(bus.x_out), 0);
      check("midrst_y",      int'(bus.y_out), 0);
      check("midrst_colour", int'(bus.colour_out), 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      run_counted(3, 70, 50, 1'b0, "post_rst_plots", 15);

      // Randomized requests, including exact back-to-back starts
      for (int i = 0; i < 24; i++) begin
         int gap;
         gap = $urandom_range(0, 3);
         wait_edge(last_t + 66 + gap);
         pulse($urandom_range(0, 3), $urandom_range(0, 175), $urandom_range(0, 127),
               1'($urandom_range(0, 1)));
      end
      wait_edge(last_t + 70);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
